oam_dma_ctrl: RTL

Memory-bus owner and sequencer for OAM DMA in the SM83 system. It sits between the CPU memory port and the shared memory bus (`mem_*`). When the CPU writes a source page to the DMA register (0xFF46), the block takes the bus and copies `XFER_LEN` bytes from `{page,8'h00}` to `DST_BASE`, one read/write pair at a time. While the copy runs, CPU accesses are blocked; when it finishes, bus ownership returns to the CPU.

---
 rtl/oam_dma_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: memory-bus owner and sequencer for SM83 OAM DMA.
// A CPU write to the DMA register (0xFF46) takes the shared bus and copies
// XFER_LEN bytes from {page,8'h00} to DST_BASE as read/write pairs. CPU
// accesses are blocked while the copy runs.
// Optional feature: define OAM_DMA_DONE_IRQ_EN to add the done_irq pulse.
module oam_dma_ctrl #(
  parameter int unsigned XFER_LEN = 160,
  parameter logic [15:0] DST_BASE = 16'hFE00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_wr,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_cs,
  input  logic        cpu_oe,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_cs,
  output logic        mem_oe,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
`ifdef OAM_DMA_DONE_IRQ_EN
  output logic        done_irq,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_READ,
    S_WRITE
  } state_e;

  // Index of the final byte; idx never counts past it, so an 8-bit counter
  // covers the full 256-byte case without wrapping.
  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 32'd1);

  state_e      state_q;
  logic [7:0]  idx_q;
  logic [7:0]  src_page_q;
  logic [7:0]  src_page_d;
  logic [7:0]  reg_rdata_q;
  logic [7:0]  byte_latch_q;
  logic        busy_q;
  logic [15:0] wr_addr_d;
`ifdef OAM_DMA_DONE_IRQ_EN
  logic        done_irq_q;
`endif

  // Echo pages E0-FF are mirrors of C0-DF, so fold them down before use.
  assign src_page_d = (reg_wdata >= 8'hE0) ? (reg_wdata - 8'h20) : reg_wdata;

  // Destination address wraps within 16 bits; the carry out is discarded.
  assign wr_addr_d = DST_BASE + {8'h00, idx_q};

  // Sequencer: state, byte counter, source page, data latch and registered outputs.
  // NOTE: the reset is in the sensitivity list so an asserted rst returns the
  // bus to the CPU immediately, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      src_page_q   <= '0;
      reg_rdata_q  <= '0;
      byte_latch_q <= '0;
      busy_q       <= 1'b0;
`ifdef OAM_DMA_DONE_IRQ_EN
      done_irq_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here sees
      // the pre-edge values of the others regardless of statement order.
`ifdef OAM_DMA_DONE_IRQ_EN
      done_irq_q <= 1'b0;
`endif
      if (state_q == S_READ) begin
        byte_latch_q <= mem_rdata;
      end

      if (reg_wr) begin
        // A register write always (re)starts; it overrides completion, so a
        // restart in the final WRITE suppresses the done pulse.
        reg_rdata_q <= reg_wdata;
        src_page_q  <= src_page_d;
        idx_q       <= '0;
        state_q     <= S_START;
        busy_q      <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            busy_q <= 1'b0;
          end
          S_START: begin
            state_q <= S_READ;
          end
          S_READ: begin
            state_q <= S_WRITE;
          end
          S_WRITE: begin
            if (idx_q == LAST_IDX) begin
              state_q    <= S_IDLE;
              idx_q      <= '0;
              busy_q     <= 1'b0;
`ifdef OAM_DMA_DONE_IRQ_EN
              done_irq_q <= 1'b1;
`endif
            end else begin
              idx_q   <= idx_q + 8'd1;
              state_q <= S_READ;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Bus ownership mux: CPU passes straight through unless the copy is moving data.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    mem_addr  = cpu_addr;
    mem_cs    = cpu_cs;
    mem_oe    = cpu_oe;
    mem_we    = cpu_we;
    mem_wdata = cpu_wdata;
    cpu_rdata = mem_rdata;
    case (state_q)
      S_READ: begin
        mem_addr  = {src_page_q, idx_q};
        mem_cs    = 1'b1;
        mem_oe    = 1'b1;
        mem_we    = 1'b0;
        mem_wdata = byte_latch_q;
        cpu_rdata = 8'hFF;
      end
      S_WRITE: begin
        mem_addr  = wr_addr_d;
        mem_cs    = 1'b1;
        mem_oe    = 1'b0;
        mem_we    = 1'b1;
        mem_wdata = byte_latch_q;
        cpu_rdata = 8'hFF;
      end
      default: begin
      end
    endcase
  end

  assign reg_rdata = reg_rdata_q;
  assign busy      = busy_q;
`ifdef OAM_DMA_DONE_IRQ_EN
  assign done_irq  = done_irq_q;
`endif

endmodule
